// File: rtl/dmem_access_unit.sv
// Data memory load/store initiator: accepts one request, issues a single-cycle strobe, returns a response pulse.
// Optional LSU_RANGE_CHECK_EN: flags requests with req_addr_i >= DM_DEPTH as errors.
module dmem_access_unit #(
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned DM_DEPTH = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_size_i,
    output logic        rsp_valid_o,
    output logic        rsp_err_o,
    output logic [31:0] rsp_rdata_o,
    output logic        dm_mem_read_o,
    output logic        dm_mem_write_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_write_data_o,
    output logic [2:0]  dm_size_o,
    input  logic [31:0] dm_read_data_i
);

`ifdef LSU_RANGE_CHECK_EN
    localparam bit RangeCheckEn = 1'b1;
`else
    localparam bit RangeCheckEn = 1'b0;
`endif

    localparam int unsigned CntW = $clog2(MEM_LAT + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            we_q;
    logic            err_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [2:0]      size_q;
    logic [31:0]     rdata_q;

    logic accept;
    logic size_ok;
    logic range_ok;
    logic legal;
    logic last_wait;

    assign accept    = req_valid_i && (state_q == StIdle);
    assign last_wait = (state_q == StWait) && (cnt_q == CntW'(1));

    always_comb begin
        size_ok = 1'b0;
        if (req_we_i) begin
            size_ok = (req_size_i == 3'b001) || (req_size_i == 3'b010) || (req_size_i == 3'b011);
        end else begin
            size_ok = (req_size_i != 3'b000) && (req_size_i != 3'b100) && (req_size_i != 3'b111);
        end
    end

    assign range_ok = RangeCheckEn ? (req_addr_i < 32'(DM_DEPTH)) : 1'b1;
    assign legal    = size_ok && range_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = legal ? StIssue : StResp;
                end
            end
            StIssue: begin
                if (we_q) begin
                    state_d = StResp;
                end else begin
                    state_d = StWait;
                    cnt_d   = CntW'(MEM_LAT);
                end
            end
            StWait: begin
                if (last_wait) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // dm_* registers load only on a legal accept so they hold across errors.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                err_q <= !legal;
                if (legal) begin
                    we_q    <= req_we_i;
                    addr_q  <= req_addr_i;
                    wdata_q <= req_wdata_i;
                    size_q  <= req_size_i;
                end else begin
                    rdata_q <= '0;
                end
            end
            if (last_wait) begin
                rdata_q <= dm_read_data_i;
            end
        end
    end

    assign req_ready_o     = (state_q == StIdle);
    assign rsp_valid_o     = (state_q == StResp);
    assign rsp_err_o       = (state_q == StResp) && err_q;
    assign rsp_rdata_o     = rdata_q;
    assign dm_mem_read_o   = (state_q == StIssue) && !we_q;
    assign dm_mem_write_o  = (state_q == StIssue) && we_q;
    assign dm_addr_o       = addr_q;
    assign dm_write_data_o = wdata_q;
    assign dm_size_o       = size_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed and random requests against a per-cycle latency model.
module tb_dmem_access_unit;

    localparam int unsigned MEM_LAT  = 3;
    localparam int unsigned DM_DEPTH = 64;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        dm_mem_read;
    logic        dm_mem_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_write_data;
    logic [2:0]  dm_size;
    logic [31:0] dm_read_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Last issued access and last load/error data, as visible on the outputs.
    logic [31:0] exp_addr  = '0;
    logic [31:0] exp_wdata = '0;
    logic [2:0]  exp_size  = '0;
    logic [31:0] exp_rdata = '0;

    dmem_access_unit #(
        .MEM_LAT  (MEM_LAT),
        .DM_DEPTH (DM_DEPTH)
    ) u_dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_we_i        (req_we),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .req_size_i      (req_size),
        .rsp_valid_o     (rsp_valid),
        .rsp_err_o       (rsp_err),
        .rsp_rdata_o     (rsp_rdata),
        .dm_mem_read_o   (dm_mem_read),
        .dm_mem_write_o  (dm_mem_write),
        .dm_addr_o       (dm_addr),
        .dm_write_data_o (dm_write_data),
        .dm_size_o       (dm_size),
        .dm_read_data_i  (dm_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic garbage_req();
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_size  = 3'($urandom);
    endtask

    // Called at a falling edge while idle; returns at the falling edge of the idle cycle after RESP.
    task automatic run_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] size, input logic [31:0] rdval, input string name);
        bit          legal;
        int          lat;
        logic [4:0]  st_obs;
        logic [4:0]  st_exp;
        if (we) legal = (size == 3'd1) || (size == 3'd2) || (size == 3'd3);
        else    legal = !(size == 3'd0 || size == 3'd4 || size == 3'd7);
`ifdef LSU_RANGE_CHECK_EN
        if (addr >= DM_DEPTH) legal = 1'b0;
`endif
        lat = !legal ? 1 : (we ? 2 : MEM_LAT + 2);

        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s c0 req_ready got %b want 1", name, req_ready);
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        dm_read_data = $urandom;

        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1 && legal) begin
                exp_addr  = addr;
                exp_wdata = wdata;
                exp_size  = size;
            end
            if (k == 1 && !legal) exp_rdata = '0;
            if (k == lat && legal && !we) exp_rdata = rdval;

            st_obs = {req_ready, rsp_valid, rsp_valid & rsp_err, dm_mem_read, dm_mem_write};
            st_exp = {1'b0, k == lat, (k == lat) && !legal,
                      legal && !we && k == 1, legal && we && k == 1};
            n_checks++;
            if (st_obs !== st_exp) begin
                n_fail++;
                $display("FAIL %s c%0d {ready,valid,err,rd,wr} got %b want %b",
                         name, k, st_obs, st_exp);
            end
            n_checks++;
            if ({dm_addr, dm_write_data, dm_size} !== {exp_addr, exp_wdata, exp_size}) begin
                n_fail++;
                $display("FAIL %s c%0d dm addr/wdata/size got %h/%h/%b want %h/%h/%b", name, k,
                         dm_addr, dm_write_data, dm_size, exp_addr, exp_wdata, exp_size);
            end
            n_checks++;
            if (rsp_rdata !== exp_rdata) begin
                n_fail++;
                $display("FAIL %s c%0d rsp_rdata got %h want %h", name, k, rsp_rdata, exp_rdata);
            end
            // Real load data only during the final wait cycle; noise otherwise.
            dm_read_data = (legal && !we && k == lat - 1) ? rdval : $urandom;
            garbage_req();
        end

        @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, dm_mem_read, dm_mem_write} !== 4'b1000) begin
            n_fail++;
            $display("FAIL %s idle {ready,valid,rd,wr} got %b want 1000", name,
                     {req_ready, rsp_valid, dm_mem_read, dm_mem_write});
        end
    endtask

    task automatic idle_cycles(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            garbage_req();
            @(negedge clk);
            n_checks++;
            if ({req_ready, rsp_valid, dm_mem_read, dm_mem_write} !== 4'b1000) begin
                n_fail++;
                $display("FAIL idle {ready,valid,rd,wr} got %b want 1000",
                         {req_ready, rsp_valid, dm_mem_read, dm_mem_write});
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        garbage_req();
        dm_read_data = $urandom;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err, dm_mem_read, dm_mem_write} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset ctrl {ready,valid,err,rd,wr} got %b want 10000",
                     {req_ready, rsp_valid, rsp_err, dm_mem_read, dm_mem_write});
        end
        n_checks++;
        if ({rsp_rdata, dm_addr, dm_write_data, dm_size} !== '0) begin
            n_fail++;
            $display("FAIL reset data rdata/addr/wdata/size got %h/%h/%h/%b want all 0",
                     rsp_rdata, dm_addr, dm_write_data, dm_size);
        end
        rst_n = 1'b1;
        idle_cycles(2);
    endtask

    // Asserts reset in cycle at_k of a legal load (1 = ISSUE, 2.. = WAIT).
    task automatic test_reset_mid(input int at_k);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'd9;
        req_wdata = $urandom;
        req_size  = 3'b011;
        for (int k = 1; k <= at_k; k++) begin
            @(negedge clk);
            garbage_req();
        end
        n_checks++;
        if (dm_mem_read !== (at_k == 1)) begin
            n_fail++;
            $display("FAIL rst_mid%0d pre rd got %b want %b", at_k, dm_mem_read, at_k == 1);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, dm_mem_read, dm_mem_write} !== 4'b1000) begin
            n_fail++;
            $display("FAIL rst_mid%0d async {ready,valid,rd,wr} got %b want 1000", at_k,
                     {req_ready, rsp_valid, dm_mem_read, dm_mem_write});
        end
        exp_addr  = '0;
        exp_wdata = '0;
        exp_size  = '0;
        exp_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(MEM_LAT + 4);
        n_checks++;
        if ({rsp_rdata, dm_addr} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid%0d after rdata/addr got %h/%h want 0/0", at_k, rsp_rdata, dm_addr);
        end
    endtask

    task automatic test_directed();
        run_req(1'b0, 32'd5, $urandom, 3'b011, 32'hDEADBEEF, "lw");
        idle_cycles(1);
        run_req(1'b1, 32'd7, 32'h12345678, 3'b001, $urandom, "sb");
        idle_cycles(1);
        run_req(1'b0, 32'd3, $urandom, 3'b100, $urandom, "ill_load");
        run_req(1'b1, 32'd3, $urandom, 3'b101, $urandom, "ill_store");
        idle_cycles(1);
    endtask

    task automatic test_back_to_back();
        run_req(1'b0, 32'd2, $urandom, 3'b110, 32'hA5A5_0F0F, "lhu_b2b");
        run_req(1'b1, 32'd11, 32'hCAFE_F00D, 3'b011, $urandom, "sw_b2b");
        run_req(1'b0, 32'd12, $urandom, 3'b101, 32'h0000_00FF, "lbu_b2b");
        run_req(1'b0, 32'd12, $urandom, 3'b111, $urandom, "ill_b2b");
        idle_cycles(1);
    endtask

    task automatic test_range();
        run_req(1'b0, 32'd64, $urandom, 3'b011, 32'h1357_9BDF, "ld_addr64");
        run_req(1'b1, 32'd64, 32'h0BAD_F00D, 3'b010, $urandom, "st_addr64");
        run_req(1'b0, 32'd63, $urandom, 3'b010, 32'h2468_ACE0, "ld_addr63");
        idle_cycles(1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 80)) : $urandom;
            run_req(1'($urandom), a, $urandom, 3'($urandom), $urandom, "rand");
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_range();
        test_reset_mid(1);
        test_reset_mid(2);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
